// File: rtl/fetch_unit.sv
// MIPS R2000 instruction-fetch stage: PC, IF/ID register and a one-entry skid buffer.
// Optional build macro FETCH_MISALIGN_CHECK_EN turns misaligned redirects into exceptions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic [31:0] exc_pc,
  output logic        exc_misalign
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic [31:0] redir_tgt;
  logic        misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign misalign  = redirect & (redirect_pc[1:0] != 2'b00);
  assign redir_tgt = redirect_pc;

  // Pulse only when the misaligned redirect is the event actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign & ~exception;
  end
  assign exc_misalign = misalign_q;
`else
  assign misalign     = 1'b0;
  assign redir_tgt    = {redirect_pc[31:2], 2'b00};
  assign exc_misalign = 1'b0;
`endif

  // Gated by rst_n so no request leaks out while reset is held.
  assign imem_req  = rst_n & (state == FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = pc_out + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_out   <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      exc_pc     <= '0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (exception || misalign) begin
      exc_pc     <= exception ? pc_out : redirect_pc;
      pc         <= EXC_VECTOR;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      state      <= FETCH;
    end else if (redirect) begin
      pc         <= redir_tgt;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      state      <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc + 32'd4;
            if (!stall) begin
              inst_out   <= imem_rdata;
              pc_out     <= pc;
              inst_valid <= 1'b1;
            end else begin
              skid_inst <= imem_rdata;
              skid_pc   <= pc;
              state     <= HOLD;
            end
          end else if (!stall) begin
            inst_out   <= '0;
            inst_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_out   <= skid_inst;
            pc_out     <= skid_pc;
            inst_valid <= 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory returns addr ^ 32'hC0DE_0000.
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, stall, redirect, exception;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic [31:0] inst_out, pc_out, pc_plus4, exc_pc;
  logic        inst_valid, exc_misalign;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .exception(exception),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
    .exc_pc(exc_pc), .exc_misalign(exc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = w(imem_addr);

  typedef struct {
    logic        r, s, rd, ex;
    logic [31:0] rpc;
    logic [31:0] e_inst, e_pc, e_exc, e_addr;
    logic        e_v, e_req, e_mis;
  } vec_t;

  vec_t vt[23];
  int ncmp = 0;
  int nerr = 0;

  function automatic vec_t mk(input logic r, s, rd, ex, input logic [31:0] rpc,
                              input logic [31:0] e_inst, e_pc, input logic e_v,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_exc, input logic e_mis);
    vec_t v;
    v.r = r; v.s = s; v.rd = rd; v.ex = ex; v.rpc = rpc;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_v = e_v; v.e_req = e_req;
    v.e_addr = e_addr; v.e_exc = e_exc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // r s rd ex rpc | inst pc v | req addr | exc_pc mis
    vt[0]  = mk(1,0,0,0,0,          w(0),32'h0,1,            1,32'h4,        0,0);
    vt[1]  = mk(1,0,0,0,0,          w(4),32'h4,1,            1,32'h8,        0,0);
    vt[2]  = mk(1,0,0,0,0,          w(8),32'h8,1,            1,32'hC,        0,0);
    vt[3]  = mk(1,0,0,0,0,          w(32'hC),32'hC,1,        1,32'h10,       0,0);
    vt[4]  = mk(1,1,0,0,0,          w(32'hC),32'hC,1,        0,32'h14,       0,0);
    vt[5]  = mk(1,1,0,0,0,          w(32'hC),32'hC,1,        0,32'h14,       0,0);
    vt[6]  = mk(0,1,0,0,0,          w(32'hC),32'hC,1,        0,32'h14,       0,0);
    vt[7]  = mk(1,0,0,0,0,          w(32'h10),32'h10,1,      1,32'h14,       0,0);
    vt[8]  = mk(1,0,0,0,0,          w(32'h14),32'h14,1,      1,32'h18,       0,0);
    vt[9]  = mk(1,1,0,0,0,          w(32'h14),32'h14,1,      0,32'h1C,       0,0);
    vt[10] = mk(1,1,1,0,32'h100,    0,32'h14,0,              1,32'h100,      0,0);
    vt[11] = mk(1,0,0,0,0,          w(32'h100),32'h100,1,    1,32'h104,      0,0);
    vt[12] = mk(0,0,0,0,0,          0,32'h100,0,             1,32'h104,      0,0);
    vt[13] = mk(0,1,0,0,0,          0,32'h100,0,             1,32'h104,      0,0);
    vt[14] = mk(1,0,1,0,32'h20,     0,32'h100,0,             1,32'h20,       0,0);
    vt[15] = mk(1,0,0,0,0,          w(32'h20),32'h20,1,      1,32'h24,       0,0);
    vt[16] = mk(1,0,1,1,32'h200,    0,32'h20,0,              1,32'h80,       32'h20,0);
    vt[17] = mk(1,0,0,0,0,          w(32'h80),32'h80,1,      1,32'h84,       32'h20,0);
    vt[18] = mk(1,0,1,0,32'hFFFF_FFFC, 0,32'h80,0,           1,32'hFFFF_FFFC,32'h20,0);
    vt[19] = mk(1,0,0,0,0,          w(32'hFFFF_FFFC),32'hFFFF_FFFC,1, 1,32'h0, 32'h20,0);
    vt[20] = mk(1,0,0,0,0,          w(0),32'h0,1,            1,32'h4,        32'h20,0);
`ifdef FETCH_MISALIGN_CHECK_EN
    vt[21] = mk(1,0,1,0,32'h102,    0,32'h0,0,               1,32'h80,       32'h102,1);
    vt[22] = mk(0,0,0,0,0,          0,32'h0,0,               1,32'h80,       32'h102,0);
`else
    vt[21] = mk(1,0,1,0,32'h102,    0,32'h0,0,               1,32'h100,      32'h20,0);
    vt[22] = mk(0,0,0,0,0,          0,32'h0,0,               1,32'h100,      32'h20,0);
`endif

    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
    exception = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_inst",  -1, inst_out, 0);
    chk("rst_pc",    -1, pc_out, 0);
    chk("rst_valid", -1, {31'b0, inst_valid}, 0);
    chk("rst_req",   -1, {31'b0, imem_req}, 0);
    chk("rst_exc",   -1, exc_pc, 0);
    chk("rst_mis",   -1, {31'b0, exc_misalign}, 0);
    rst_n = 1'b1;
    #1 chk("first_req", -1, {31'b0, imem_req}, 1);
    chk("first_addr", -1, imem_addr, 32'h0);

    foreach (vt[i]) begin
      imem_ready = vt[i].r; stall = vt[i].s; redirect = vt[i].rd;
      exception = vt[i].ex; redirect_pc = vt[i].rpc;
      @(posedge clk);
      @(negedge clk);
      chk("inst_out",  i, inst_out, vt[i].e_inst);
      chk("pc_out",    i, pc_out, vt[i].e_pc);
      chk("pc_plus4",  i, pc_plus4, vt[i].e_pc + 32'd4);
      chk("valid",     i, {31'b0, inst_valid}, {31'b0, vt[i].e_v});
      chk("imem_req",  i, {31'b0, imem_req}, {31'b0, vt[i].e_req});
      chk("imem_addr", i, imem_addr, vt[i].e_addr);
      chk("exc_pc",    i, exc_pc, vt[i].e_exc);
      chk("misalign",  i, {31'b0, exc_misalign}, {31'b0, vt[i].e_mis});
    end

    // Reset while a word sits in the skid buffer: it must never reappear.
    imem_ready = 1'b1; stall = 1'b1; redirect = 1'b0; exception = 1'b0;
    @(posedge clk);
    #2 chk("hold_req", 100, {31'b0, imem_req}, 0);
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", 100, {31'b0, inst_valid}, 0);
    chk("mid_rst_inst", 100, inst_out, 0);
    chk("mid_rst_req",  100, {31'b0, imem_req}, 0);
    chk("mid_rst_exc",  100, exc_pc, 0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    #1 chk("post_rst_req",  101, {31'b0, imem_req}, 1);
    chk("post_rst_addr", 101, imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("no_skid_valid", 102, {31'b0, inst_valid}, 0);
    chk("no_skid_addr",  102, imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_inst", 103, inst_out, w(0));
    chk("restart_pc",   103, pc_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS R2000 pipeline: the producer end of the instruction word consumed by the decode stage. Holds the program counter and issues word reads to instruction memory. Registers the returned instruction into the IF/ID pipeline register. Handles hazard stalls with a one-entry skid buffer and redirects the PC on branch/jump or exception, inserting a bubble on each redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded when an exception is taken.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; always equals the current pc.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard unit freezes IF/ID.
- redirect  in  1  branch taken or jump from decode.
- redirect_pc  in  32  target address for redirect.
- exception  in  1  exception request.
- inst_out  out  32  IF/ID instruction (to decode inst_in).
- pc_out  out  32  address of inst_out.
- pc_plus4  out  32  pc_out + 4.
- inst_valid  out  1  inst_out holds a real instruction, not a bubble.
- exc_pc  out  32  pc_out captured when an exception is taken.
- exc_misalign  out  1  one-cycle pulse on a misaligned redirect (macro only).

## Operation
- State: pc, IF/ID register (inst_out, pc_out, inst_valid), skid buffer (skid_inst, skid_pc), FSM {FETCH, HOLD}.
- Per-cycle priority: exception > redirect > stall > normal fetch.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ready with stall=0: IF/ID loads {imem_rdata, pc, 1}; pc advances to pc+4.
  - On imem_ready with stall=1: IF/ID holds; skid buffer loads {imem_rdata, pc}; pc advances to pc+4; go to HOLD.
  - No imem_ready: IF/ID loads a bubble (inst_out=0, inst_valid=0) if stall=0, else holds.
- HOLD:
  - imem_req=0.
  - While stall=1: IF/ID and skid buffer hold.
  - When stall=0: IF/ID loads {skid_inst, skid_pc, 1}; go to FETCH.
- Redirect (any state):
  - pc loads redirect_pc.
  - IF/ID becomes a bubble even if stall=1.
  - Skid buffer is discarded; go to FETCH.
  - A word returned in the same cycle is dropped.
- Exception (any state):
  - exc_pc loads pc_out; pc loads EXC_VECTOR.
  - Bubble and discard rules are the same as redirect.
- Arithmetic: 32-bit, modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- pc_plus4 is combinational: pc_out + 4.

## Timing
- Reset values (asserted asynchronously):
  - pc=RESET_PC; FSM=FETCH.
  - inst_out=0, pc_out=0, inst_valid=0, exc_pc=0, exc_misalign=0.
  - imem_req=0 while rst_n=0.
- First request occurs in the first cycle after rst_n rises.
- Latency: 1 cycle from an accepted imem_ready to inst_out.
- Throughput: 1 instruction/cycle with imem_ready tied high and stall=0.
- Stall: asserting stall freezes inst_out in the same edge. Deasserting stall from HOLD presents the skid word at the next edge with no extra bubble.
- Redirect/exception: the bubble appears at the next edge; the target word appears 1 cycle after the target is accepted.
- Reset mid-operation discards all state, including the skid buffer and any accepted word.

## Configuration
- FETCH_MISALIGN_CHECK_EN
  - Defined: a redirect_pc with [1:0]≠0 is treated as an exception.
    - pc=EXC_VECTOR, exc_pc=redirect_pc, exc_misalign pulses for 1 cycle.
  - Undefined: redirect_pc[1:0] is forced to 00, exc_misalign is tied 0, and no exception is raised.

## Test plan
- Reset, then run 4 cycles with ready=1 and words A,B,C,D -> inst_out=A at cycle 2 with pc_out=0, then B/C/D, pc_plus4 tracks; inst_valid stays 1.
- Stall for 3 cycles while B returns -> inst_out holds A, imem_req=0 in HOLD; on release inst_out=B, pc_out=4, no bubble, no lost or duplicated word.
- Redirect to 0x100 with stall=1 in HOLD -> next edge inst_valid=0, skid word dropped; following cycle imem_addr=0x100, and the word from 0x100 appears next.
- Exception with pc_out=0x20 coincident with redirect -> pc=0x80, exc_pc=0x20, redirect ignored.
- Run from pc=0xFFFF_FFFC -> next imem_addr=0x0000_0000.
- Macro defined, redirect_pc=0x102 -> exc_misalign=1 for 1 cycle, pc=0x80, exc_pc=0x102. Macro undefined, same stimulus -> imem_addr=0x100.
